ssd_bin2bcd_seq: RTL and testbench

- Sequential shift-and-add-3 (double-dabble) converter from an unsigned binary value to packed BCD digits.
- Sits directly upstream of the four-digit seven-segment display driver, in the SSD clock domain.
- Takes the 13-bit SSD value selected out of the processor and delivers stable decimal digits for multiplexed display.
- Start/busy/done handshake; the output register holds the last completed result so the display never shows partial values.

---
 rtl/ssd_bin2bcd_seq_pkg.sv | 28 ++
 rtl/ssd_bin2bcd_seq_if.sv | 39 +++
 rtl/ssd_bin2bcd_seq_add3.sv | 13 +
 rtl/ssd_bin2bcd_seq.sv | 122 ++++++++++++
 tb/tb_ssd_bin2bcd_seq.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ssd_bin2bcd_seq_pkg.sv
// ssd_pkg: shared types and constants for the SSD binary-to-BCD converter.
//   state_t            converter FSM states
//   BCD_DIGIT_W        width of one packed BCD digit
//   ADD3_THRESH        digit value at which double-dabble adds 3
//   SSD_DIGITS_DEFAULT default number of display digits
//   bcd_max()          largest value representable in a given digit count
package ssd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LOAD  = 2'd2
   } state_t;

   localparam int          BCD_DIGIT_W        = 4;
   localparam logic [3:0]  ADD3_THRESH        = 4'd5;
   localparam int          SSD_DIGITS_DEFAULT = 4;

   function automatic longint unsigned bcd_max(input int digits);
      longint unsigned v;
      v = 1;
      for (int i = 0; i < digits; i++) begin
         v = v * 10;
      end
      return v - 1;
   endfunction

endpackage

// File: rtl/ssd_bin2bcd_seq_if.sv
// ssd_bin2bcd_seq_if: handshake and data bundle for ssd_bin2bcd_seq.
//   BinIn     binary value to convert (master -> slave)
//   start     conversion request, level-sensitive (master -> slave)
//   busy      conversion in progress (slave -> master)
//   done      one-cycle pulse when BcdOut updates (slave -> master)
//   BcdOut    packed BCD, digit 0 in [3:0] (slave -> master)
//   ovf       last accepted value did not fit in DIGITS digits
//   BlankMask leading-zero blanking mask, only with SSD_BIN2BCD_BLANK_EN
interface ssd_bin2bcd_seq_if #(
   parameter int WIDTH  = 13,
   parameter int DIGITS = 4
);
   logic [WIDTH-1:0]    BinIn;
   logic                start;
   logic                busy;
   logic                done;
   logic [4*DIGITS-1:0] BcdOut;
   logic                ovf;
`ifdef SSD_BIN2BCD_BLANK_EN
   logic [DIGITS-1:0]   BlankMask;
`endif

   modport master (
      output BinIn, start,
`ifdef SSD_BIN2BCD_BLANK_EN
      input  BlankMask,
`endif
      input  busy, done, BcdOut, ovf
   );

   modport slave (
      input  BinIn, start,
`ifdef SSD_BIN2BCD_BLANK_EN
      output BlankMask,
`endif
      output busy, done, BcdOut, ovf
   );

endinterface

// File: rtl/ssd_bin2bcd_seq_add3.sv
// bcd_add3: combinational double-dabble digit correction.
//   digit_in  4-bit BCD digit before the shift
//   digit_out digit_in + 3 when digit_in >= 5, else digit_in
module bcd_add3
   import ssd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] digit_in,
   output logic [BCD_DIGIT_W-1:0] digit_out
);

   assign digit_out = (digit_in >= ADD3_THRESH) ? digit_in + 4'd3 : digit_in;

endmodule

// File: rtl/ssd_bin2bcd_seq.sv
// ssd_bin2bcd_seq: sequential shift-and-add-3 binary to packed BCD converter
// feeding the four-digit seven-segment driver.
//   SSDClk  display-domain clock
//   rst     asynchronous active-low reset
//   bus     ssd_bin2bcd_seq_if.slave (BinIn/start in; busy/done/BcdOut/ovf out)
// Optional: SSD_BIN2BCD_BLANK_EN adds bus.BlankMask (leading-zero blanking).
//
// state | meaning
// IDLE  | waiting for start; BcdOut holds last result
// SHIFT | one add-3 + shift per cycle, WIDTH cycles
// LOAD  | publish scratch (or all 9s on overflow), pulse done
module ssd_bin2bcd_seq
   import ssd_pkg::*;
#(
   parameter int WIDTH  = 13,
   parameter int DIGITS = SSD_DIGITS_DEFAULT
) (
   input  logic SSDClk,
   input  logic rst,
   ssd_bin2bcd_seq_if.slave bus
);

   localparam int SCR_W = BCD_DIGIT_W * DIGITS;
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam longint unsigned MAX_VAL = bcd_max(DIGITS);

   state_t             state;
   logic [WIDTH-1:0]   shift_q;
   logic [SCR_W-1:0]   scratch_q;
   logic [SCR_W-1:0]   scratch_adj;
   logic [SCR_W+WIDTH-1:0] shifted;
   logic [CNT_W-1:0]   cnt_q;
   logic               ovf_pend;
   logic               busy_q;
   logic               done_q;
   logic [SCR_W-1:0]   bcd_q;
   logic               ovf_q;

   for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .digit_in  (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .digit_out (scratch_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

   // Scratch and binary move as one word so the binary MSB lands in scratch bit 0.
   assign shifted = {scratch_adj, shift_q} << 1;

`ifdef SSD_BIN2BCD_BLANK_EN
   logic [DIGITS-1:0] blank_q;
   logic [DIGITS-1:0] blank_next;
   logic              zero_above;

   // Walk from the top digit down; bit 0 stays clear so zero still shows one digit.
   always_comb begin
      blank_next = '0;
      zero_above = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_above = zero_above && (scratch_q[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
         blank_next[i] = zero_above && (i != 0);
      end
   end

   assign bus.BlankMask = blank_q;
`endif

   always_ff @(posedge SSDClk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         shift_q   <= '0;
         scratch_q <= '0;
         cnt_q     <= '0;
         ovf_pend  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         bcd_q     <= '0;
         ovf_q     <= 1'b0;
`ifdef SSD_BIN2BCD_BLANK_EN
         blank_q   <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  shift_q   <= bus.BinIn;
                  scratch_q <= '0;
                  cnt_q     <= CNT_W'(WIDTH);
                  // The binary is consumed by shifting, so decide overflow now.
                  ovf_pend  <= (64'(bus.BinIn) > MAX_VAL);
                  busy_q    <= 1'b1;
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               {scratch_q, shift_q} <= shifted;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) begin
                  state <= LOAD;
               end
            end
            LOAD: begin
               bcd_q  <= ovf_pend ? {DIGITS{4'h9}} : scratch_q;
               ovf_q  <= ovf_pend;
               busy_q <= 1'b0;
               done_q <= 1'b1;
`ifdef SSD_BIN2BCD_BLANK_EN
               blank_q <= ovf_pend ? '0 : blank_next;
`endif
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.BcdOut = bcd_q;
   assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_ssd_bin2bcd_seq.sv
// tb_ssd_bin2bcd_seq: directed self-checking bench for ssd_bin2bcd_seq.
// Two instances: default WIDTH=13, and WIDTH=14 for the overflow cases.
// Define SSD_BIN2BCD_BLANK_EN to also check BlankMask.
`timescale 1ns/1ps
module tb_ssd_bin2bcd_seq;

   logic SSDClk;
   logic rst;
   int   vectors;
   int   miscompares;

   ssd_bin2bcd_seq_if #(.WIDTH(13), .DIGITS(4)) bus13 ();
   ssd_bin2bcd_seq_if #(.WIDTH(14), .DIGITS(4)) bus14 ();

   ssd_bin2bcd_seq #(.WIDTH(13), .DIGITS(4)) dut13 (
      .SSDClk (SSDClk),
      .rst    (rst),
      .bus    (bus13.slave)
   );

   ssd_bin2bcd_seq #(.WIDTH(14), .DIGITS(4)) dut14 (
      .SSDClk (SSDClk),
      .rst    (rst),
      .bus    (bus14.slave)
   );

   initial begin
      SSDClk = 1'b0;
      forever #5 SSDClk = ~SSDClk;
   end

   task automatic tick();
      @(posedge SSDClk);
      #1;
   endtask

   // Pulse start on the 13-bit instance and return cycles from acceptance to done.
   task automatic convert13(input logic [12:0] v, output int cyc);
      bus13.BinIn = v;
      bus13.start = 1'b1;
      tick();
      bus13.start = 1'b0;
      cyc = -1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (bus13.done === 1'b1) begin
            cyc = k;
            break;
         end
      end
   endtask

   task automatic convert14(input logic [13:0] v, output int cyc);
      bus14.BinIn = v;
      bus14.start = 1'b1;
      tick();
      bus14.start = 1'b0;
      cyc = -1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (bus14.done === 1'b1) begin
            cyc = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bus13.BinIn = 13'($urandom);
         bus13.start = 1'($urandom_range(0, 1));
         tick();
      end
      vectors++;
      if ({bus13.BcdOut, bus13.busy, bus13.done, bus13.ovf} !== {16'h0000, 3'b000}) begin
         miscompares++;
         $display("FAIL reset_hold: got bcd=%h busy=%b done=%b ovf=%b want 0000/0/0/0",
                  bus13.BcdOut, bus13.busy, bus13.done, bus13.ovf);
      end
      bus13.start = 1'b0;
      rst = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      vectors++;
      if ({bus13.BcdOut, bus13.busy, bus13.done, bus13.ovf} !== {16'h0000, 3'b000}) begin
         miscompares++;
         $display("FAIL reset_release: got bcd=%h busy=%b done=%b ovf=%b want 0000/0/0/0",
                  bus13.BcdOut, bus13.busy, bus13.done, bus13.ovf);
      end
   endtask

   task automatic test_latency();
      int cyc;
      bus13.BinIn = 13'd1234;
      bus13.start = 1'b1;
      tick();
      bus13.start = 1'b0;
      vectors++;
      if (bus13.busy !== 1'b1) begin
         miscompares++;
         $display("FAIL busy_rise: got %b want 1", bus13.busy);
      end
      cyc = -1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (bus13.done === 1'b1) begin
            cyc = k;
            break;
         end
      end
      vectors++;
      if (cyc !== 14) begin
         miscompares++;
         $display("FAIL latency_1234: got %0d cycles want 14", cyc);
      end
      vectors++;
      if ({bus13.BcdOut, bus13.ovf, bus13.busy} !== {16'h1234, 2'b00}) begin
         miscompares++;
         $display("FAIL value_1234: got bcd=%h ovf=%b busy=%b want 1234/0/0",
                  bus13.BcdOut, bus13.ovf, bus13.busy);
      end
      tick();
      vectors++;
      if (bus13.done !== 1'b0) begin
         miscompares++;
         $display("FAIL done_width: got %b want 0", bus13.done);
      end
   endtask

   task automatic test_values();
      logic [12:0] vin  [7];
      logic [15:0] vexp [7];
      int cyc;
      vin[0] = 13'd5;    vexp[0] = 16'h0005;
      vin[1] = 13'd9;    vexp[1] = 16'h0009;
      vin[2] = 13'd10;   vexp[2] = 16'h0010;
      vin[3] = 13'd99;   vexp[3] = 16'h0099;
      vin[4] = 13'd1000; vexp[4] = 16'h1000;
      vin[5] = 13'd4095; vexp[5] = 16'h4095;
      vin[6] = 13'd7059; vexp[6] = 16'h7059;
      for (int i = 0; i < 7; i++) begin
         convert13(vin[i], cyc);
         vectors++;
         if (cyc !== 14 || bus13.BcdOut !== vexp[i] || bus13.ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL value_%0d: got bcd=%h ovf=%b cyc=%0d want %h/0/14",
                     vin[i], bus13.BcdOut, bus13.ovf, cyc, vexp[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int k1;
      int k2;
      bus13.BinIn = 13'd8191;
      bus13.start = 1'b1;
      tick();
      bus13.BinIn = 13'd0;
      k1 = -1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (bus13.done === 1'b1) begin
            k1 = k;
            break;
         end
      end
      vectors++;
      if (k1 !== 14 || bus13.BcdOut !== 16'h8191 || bus13.ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_first: got bcd=%h ovf=%b cyc=%0d want 8191/0/14",
                  bus13.BcdOut, bus13.ovf, k1);
      end
      k2 = -1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (bus13.done === 1'b1) begin
            k2 = k;
            break;
         end
      end
      bus13.start = 1'b0;
      vectors++;
      if (k2 !== 15 || bus13.BcdOut !== 16'h0000) begin
         miscompares++;
         $display("FAIL b2b_second: got bcd=%h gap=%0d want 0000/15", bus13.BcdOut, k2);
      end
      for (int k = 0; k < 20; k++) tick();
   endtask

   task automatic test_start_ignored();
      int cyc;
      int extra;
      bus13.BinIn = 13'd42;
      bus13.start = 1'b1;
      tick();
      bus13.start = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      bus13.BinIn = 13'd999;
      bus13.start = 1'b1;
      tick();
      bus13.start = 1'b0;
      cyc = -1;
      for (int k = 6; k <= 40; k++) begin
         tick();
         if (bus13.done === 1'b1) begin
            cyc = k;
            break;
         end
      end
      vectors++;
      if (cyc !== 14 || bus13.BcdOut !== 16'h0042) begin
         miscompares++;
         $display("FAIL ignore_start: got bcd=%h cyc=%0d want 0042/14", bus13.BcdOut, cyc);
      end
      extra = 0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (bus13.done === 1'b1) extra++;
      end
      vectors++;
      if (extra !== 0 || bus13.BcdOut !== 16'h0042) begin
         miscompares++;
         $display("FAIL ignore_no_done: got %0d extra done bcd=%h want 0 and 0042",
                  extra, bus13.BcdOut);
      end
   endtask

   task automatic test_reset_mid();
      int seen;
      bus13.BinIn = 13'd5000;
      bus13.start = 1'b1;
      tick();
      bus13.start = 1'b0;
      for (int k = 0; k < 6; k++) tick();
      rst = 1'b0;
      #1;
      vectors++;
      if ({bus13.BcdOut, bus13.busy, bus13.done, bus13.ovf} !== {16'h0000, 3'b000}) begin
         miscompares++;
         $display("FAIL reset_mid_clear: got bcd=%h busy=%b done=%b ovf=%b want 0000/0/0/0",
                  bus13.BcdOut, bus13.busy, bus13.done, bus13.ovf);
      end
      tick();
      rst = 1'b1;
      seen = 0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (bus13.done === 1'b1 || bus13.busy === 1'b1) seen++;
      end
      vectors++;
      if (seen !== 0 || bus13.BcdOut !== 16'h0000) begin
         miscompares++;
         $display("FAIL reset_mid_after: got %0d busy/done cycles bcd=%h want 0 and 0000",
                  seen, bus13.BcdOut);
      end
   endtask

   task automatic test_overflow();
      int cyc;
      convert14(14'd12345, cyc);
      vectors++;
      if (cyc !== 15 || bus14.BcdOut !== 16'h9999 || bus14.ovf !== 1'b1) begin
         miscompares++;
         $display("FAIL ovf_12345: got bcd=%h ovf=%b cyc=%0d want 9999/1/15",
                  bus14.BcdOut, bus14.ovf, cyc);
      end
`ifdef SSD_BIN2BCD_BLANK_EN
      vectors++;
      if (bus14.BlankMask !== 4'b0000) begin
         miscompares++;
         $display("FAIL blank_ovf: got %b want 0000", bus14.BlankMask);
      end
`endif
      convert14(14'd9999, cyc);
      vectors++;
      if (bus14.BcdOut !== 16'h9999 || bus14.ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL ovf_9999: got bcd=%h ovf=%b want 9999/0", bus14.BcdOut, bus14.ovf);
      end
      convert14(14'd10000, cyc);
      vectors++;
      if (bus14.BcdOut !== 16'h9999 || bus14.ovf !== 1'b1) begin
         miscompares++;
         $display("FAIL ovf_10000: got bcd=%h ovf=%b want 9999/1", bus14.BcdOut, bus14.ovf);
      end
      convert14(14'd305, cyc);
      vectors++;
      if (bus14.BcdOut !== 16'h0305 || bus14.ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL ovf_clear_305: got bcd=%h ovf=%b want 0305/0", bus14.BcdOut, bus14.ovf);
      end
   endtask

`ifdef SSD_BIN2BCD_BLANK_EN
   task automatic test_blank();
      logic [12:0] vin  [5];
      logic [3:0]  mexp [5];
      int cyc;
      vin[0] = 13'd42;   mexp[0] = 4'b1100;
      vin[1] = 13'd0;    mexp[1] = 4'b1110;
      vin[2] = 13'd8191; mexp[2] = 4'b0000;
      vin[3] = 13'd7;    mexp[3] = 4'b1110;
      vin[4] = 13'd120;  mexp[4] = 4'b1000;
      for (int i = 0; i < 5; i++) begin
         convert13(vin[i], cyc);
         vectors++;
         if (cyc !== 14 || bus13.BlankMask !== mexp[i]) begin
            miscompares++;
            $display("FAIL blank_%0d: got %b cyc=%0d want %b/14",
                     vin[i], bus13.BlankMask, cyc, mexp[i]);
         end
      end
   endtask
`endif

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b0;
      bus13.BinIn = '0;
      bus13.start = 1'b0;
      bus14.BinIn = '0;
      bus14.start = 1'b0;

      test_reset();
      test_latency();
      test_values();
      test_back_to_back();
      test_start_ignored();
      test_reset_mid();
      test_overflow();
`ifdef SSD_BIN2BCD_BLANK_EN
      test_blank();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
